// File: rtl/fb_pkg.sv
// Shared constants and encodings for the frame-buffer port arbiter.
package fb_pkg;

  localparam int c_img_pxls    = 4800;
  localparam int c_nb_img_pxls = 13;
  localparam int c_nb_buf      = 12;
  localparam int c_wfifo_depth = 4;
  localparam int c_nb_wfifo    = 2;

  localparam logic [c_nb_img_pxls-1:0] c_img_lim = c_nb_img_pxls'(c_img_pxls);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_DET  = 2'd2
  } rd_tag_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_CAM  = 2'd2,
    GNT_DET  = 2'd3
  } gnt_t;

  function automatic logic in_range(input logic [c_nb_img_pxls-1:0] addr);
    return addr < c_img_lim;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small circular-buffer FIFO; a push while full is accepted only alongside a pop.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] c_full_cnt = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == c_full_cnt);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Fixed-priority owner of the single frame-buffer BRAM port: display, then
// buffered camera writes, then detector reads; read data returns two cycles later.
module fb_port_arbiter
  import fb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_rd,
  input  logic [c_nb_img_pxls-1:0] disp_addr,
  output logic [c_nb_buf-1:0]      disp_data,
  output logic                     disp_valid,
  input  logic                     cam_we,
  input  logic [c_nb_img_pxls-1:0] cam_addr,
  input  logic [c_nb_buf-1:0]      cam_data,
  output logic                     cam_full,
  output logic                     cam_ovf,
  input  logic                     det_req,
  input  logic [c_nb_img_pxls-1:0] det_addr,
  output logic                     det_gnt,
  output logic [c_nb_buf-1:0]      det_data,
  output logic                     det_valid,
  input  logic                     ovf_clr,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [c_nb_img_pxls-1:0] mem_addr,
  output logic [c_nb_buf-1:0]      mem_wdata,
  input  logic [c_nb_buf-1:0]      mem_rdata
);

  localparam int c_nb_ent = c_nb_img_pxls + c_nb_buf;
  localparam logic [c_nb_wfifo:0] c_full_cnt = (c_nb_wfifo + 1)'(c_wfifo_depth);

  gnt_t                gnt;
  rd_tag_t             tag_d, tag_q;
  logic                oor_d, oor_q;
  logic                cam_push, cam_pop;
  logic                fifo_full, fifo_empty;
  logic [c_nb_wfifo:0] fifo_count;
  logic [c_nb_ent-1:0] fifo_head;

  // Out-of-range camera writes never enter the FIFO, so every popped entry is valid.
  assign cam_push = cam_we && in_range(cam_addr);
  assign cam_pop  = (gnt == GNT_CAM);
  assign cam_full = (fifo_count == c_full_cnt);

  fb_wr_fifo #(
    .DEPTH (c_wfifo_depth),
    .AW    (c_nb_wfifo),
    .W     (c_nb_ent)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cam_push),
    .push_data ({cam_addr, cam_data}),
    .pop       (cam_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Handshake: det_req is held with a stable det_addr until det_gnt pulses; the
  // grant cycle is the issue cycle, so det_req may drop or change on the next cycle.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (disp_rd)          gnt = GNT_DISP;
      else if (!fifo_empty) gnt = GNT_CAM;
      else if (det_req)     gnt = GNT_DET;
    end
  end

  assign det_gnt = (gnt == GNT_DET);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = TAG_NONE;
    oor_d     = 1'b0;
    unique case (gnt)
      GNT_DISP: begin
        tag_d    = TAG_DISP;
        oor_d    = !in_range(disp_addr);
        mem_en   = in_range(disp_addr);
        mem_addr = disp_addr;
      end
      GNT_CAM: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_head[c_nb_ent-1 -: c_nb_img_pxls];
        mem_wdata = fifo_head[c_nb_buf-1:0];
      end
      GNT_DET: begin
        tag_d    = TAG_DET;
        oor_d    = !in_range(det_addr);
        mem_en   = in_range(det_addr);
        mem_addr = det_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= TAG_NONE;
      oor_q      <= 1'b0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      det_data   <= '0;
      det_valid  <= 1'b0;
      cam_ovf    <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      oor_q      <= oor_d;
      disp_valid <= (tag_q == TAG_DISP);
      det_valid  <= (tag_q == TAG_DET);
      if (tag_q == TAG_DISP) disp_data <= oor_q ? '0 : mem_rdata;
      if (tag_q == TAG_DET)  det_data  <= oor_q ? '0 : mem_rdata;
      if (cam_push && fifo_full && !cam_pop) cam_ovf <= 1'b1;
      else if (ovf_clr)                      cam_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural BRAM and a BRAM-write scoreboard.
module tb_fb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        disp_rd;
  logic [12:0] disp_addr;
  logic [11:0] disp_data;
  logic        disp_valid;
  logic        cam_we;
  logic [12:0] cam_addr;
  logic [11:0] cam_data;
  logic        cam_full;
  logic        cam_ovf;
  logic        det_req;
  logic [12:0] det_addr;
  logic        det_gnt;
  logic [11:0] det_data;
  logic        det_valid;
  logic        ovf_clr;
  logic        mem_en;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [11:0] bram [4800];
  logic [24:0] exp_q [$];

  fb_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .disp_rd    (disp_rd),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .cam_we     (cam_we),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .cam_full   (cam_full),
    .cam_ovf    (cam_ovf),
    .det_req    (det_req),
    .det_addr   (det_addr),
    .det_gnt    (det_gnt),
    .det_data   (det_data),
    .det_valid  (det_valid),
    .ovf_clr    (ovf_clr),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  // ---------------- BRAM model ----------------
  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 4800; i++) bram[i] = '0;
    bram[1] = 12'h111;
    bram[2] = 12'h222;
    bram[5] = 12'hABC;
    bram[7] = 12'h777;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Every BRAM write must match the next expected {addr, data} in order.
  always @(negedge clk) begin
    if (!rst && mem_en && mem_we) begin
      if (exp_q.size() == 0) check("unexpected_wr", 32'({mem_addr, mem_wdata}), 32'hFFFF_FFFF);
      else                   check("wr_order", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    disp_rd = 0; disp_addr = '0;
    cam_we  = 0; cam_addr  = '0; cam_data = '0;
    det_req = 0; det_addr  = '0;
    ovf_clr = 0;
  endtask

  task automatic cam_push(input logic [12:0] a, input logic [11:0] d, input bit expect_write);
    cam_we = 1; cam_addr = a; cam_data = d;
    if (expect_write) exp_q.push_back({a, d});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst = 1;
    #21;
    check("rst_cam_full", 32'(cam_full), 0);
    check("rst_cam_ovf", 32'(cam_ovf), 0);
    check("rst_disp_data", 32'(disp_data), 0);
    check("rst_det_data", 32'(det_data), 0);
    check("rst_disp_valid", 32'(disp_valid), 0);
    check("rst_det_valid", 32'(det_valid), 0);
    check("rst_det_gnt", 32'(det_gnt), 0);
    rst = 0;
    repeat (8) tick();

    // Basic display read, two-cycle latency.
    tick(); disp_rd = 1; disp_addr = 13'd5; settle();
    check("t1_mem_en", 32'(mem_en), 1);
    check("t1_mem_we", 32'(mem_we), 0);
    check("t1_mem_addr", 32'(mem_addr), 5);
    tick(); disp_rd = 0; settle();
    check("t1_valid_n1", 32'(disp_valid), 0);
    tick(); settle();
    check("t1_valid_n2", 32'(disp_valid), 1);
    check("t1_data_n2", 32'(disp_data), 32'h0ABC);
    tick(); settle();
    check("t1_valid_n3", 32'(disp_valid), 0);
    check("t1_data_hold", 32'(disp_data), 32'h0ABC);

    // Collision: display, one queued camera write, detector, all at N.
    tick(); cam_push(13'd10, 12'h123, 1); settle();
    tick(); cam_we = 0; disp_rd = 1; disp_addr = 13'd1; det_req = 1; det_addr = 13'd2; settle();
    check("t2_n_disp_addr", 32'(mem_addr), 1);
    check("t2_n_we", 32'(mem_we), 0);
    check("t2_n_gnt", 32'(det_gnt), 0);
    tick(); disp_rd = 0; settle();
    check("t2_n1_we", 32'(mem_we), 1);
    check("t2_n1_addr", 32'(mem_addr), 10);
    check("t2_n1_gnt", 32'(det_gnt), 0);
    tick(); settle();
    check("t2_n2_gnt", 32'(det_gnt), 1);
    check("t2_n2_addr", 32'(mem_addr), 2);
    check("t2_n2_we", 32'(mem_we), 0);
    check("t2_n2_disp_valid", 32'(disp_valid), 1);
    check("t2_n2_disp_data", 32'(disp_data), 32'h111);
    tick(); det_req = 0; settle();
    check("t2_n3_gnt", 32'(det_gnt), 0);
    check("t2_n3_det_valid", 32'(det_valid), 0);
    tick(); settle();
    check("t2_n4_det_valid", 32'(det_valid), 1);
    check("t2_n4_det_data", 32'(det_data), 32'h222);

    // Overflow: display blocks the FIFO for 8 cycles while 6 writes arrive.
    for (int c = 0; c < 8; c++) begin
      tick();
      disp_rd = 1; disp_addr = 13'd7;
      if (c < 6) cam_push(13'(c), 12'(32'h100 + c), c < 4);
      else       cam_we = 0;
      settle();
      check("t3_disp_issue", 32'(mem_addr), 7);
      if (c == 3) check("t3_full_c3", 32'(cam_full), 0);
      if (c == 4) check("t3_full_c4", 32'(cam_full), 1);
      if (c == 4) check("t3_ovf_c4", 32'(cam_ovf), 0);
      if (c == 5) check("t3_ovf_c5", 32'(cam_ovf), 1);
    end
    tick(); disp_rd = 0; settle();
    check("t3_first_wr_addr", 32'(mem_addr), 0);
    check("t3_full_c8", 32'(cam_full), 1);
    tick(); settle();
    check("t3_full_c9", 32'(cam_full), 0);
    repeat (2) tick();
    tick(); ovf_clr = 1; settle();
    check("t3_idle_en", 32'(mem_en), 0);
    check("t3_ovf_before_clr", 32'(cam_ovf), 1);
    tick(); ovf_clr = 0; settle();
    check("t3_ovf_cleared", 32'(cam_ovf), 0);

    // Push while full, in the same cycle as a camera grant.
    for (int c = 0; c < 4; c++) begin
      tick(); disp_rd = 1; disp_addr = 13'd7; cam_push(13'(20 + c), 12'(32'h200 + c), 1); settle();
    end
    tick(); disp_rd = 0; cam_push(13'd24, 12'h204, 1); settle();
    check("t4_full_pushpop", 32'(cam_full), 1);
    check("t4_pop_addr", 32'(mem_addr), 20);
    tick(); cam_we = 0; settle();
    check("t4_full_after", 32'(cam_full), 1);
    check("t4_ovf", 32'(cam_ovf), 0);
    tick(); tick(); tick(); settle();
    check("t4_new_entry_addr", 32'(mem_addr), 24);
    check("t4_new_entry_data", 32'(mem_wdata), 32'h204);
    tick(); settle();
    check("t4_drained", 32'(cam_full), 0);
    check("t4_idle_en", 32'(mem_en), 0);

    // Out-of-range display, detector and camera requests.
    tick(); disp_rd = 1; disp_addr = 13'd4800; settle();
    check("t5_disp_oor_en", 32'(mem_en), 0);
    tick(); disp_rd = 0; settle();
    check("t5_disp_oor_v1", 32'(disp_valid), 0);
    tick(); settle();
    check("t5_disp_oor_valid", 32'(disp_valid), 1);
    check("t5_disp_oor_data", 32'(disp_data), 0);
    tick(); det_req = 1; det_addr = 13'd4800; settle();
    check("t5_det_oor_gnt", 32'(det_gnt), 1);
    check("t5_det_oor_en", 32'(mem_en), 0);
    tick(); det_req = 0; settle();
    check("t5_det_oor_v1", 32'(det_valid), 0);
    tick(); settle();
    check("t5_det_oor_valid", 32'(det_valid), 1);
    check("t5_det_oor_data", 32'(det_data), 0);
    tick(); cam_push(13'd4800, 12'h555, 0); settle();
    tick(); cam_we = 0; settle();
    check("t5_cam_oor_en", 32'(mem_en), 0);
    check("t5_cam_oor_full", 32'(cam_full), 0);
    tick(); settle();
    check("t5_cam_oor_ovf", 32'(cam_ovf), 0);

    // Reset with a display read in flight and a camera entry queued.
    tick(); disp_rd = 1; disp_addr = 13'd5; cam_push(13'd30, 12'h330, 0); settle();
    tick(); idle_inputs(); rst = 1; settle();
    check("t6_rst_valid", 32'(disp_valid), 0);
    check("t6_rst_disp_data", 32'(disp_data), 0);
    check("t6_rst_det_data", 32'(det_data), 0);
    check("t6_rst_mem_en", 32'(mem_en), 0);
    check("t6_rst_full", 32'(cam_full), 0);
    tick(); settle();
    check("t6_rst_valid2", 32'(disp_valid), 0);
    tick(); rst = 0; settle();
    for (int c = 0; c < 3; c++) begin
      check("t6_post_valid", 32'(disp_valid), 0);
      check("t6_post_mem_en", 32'(mem_en), 0);
      tick(); settle();
    end

    check("wr_queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port synchronous frame-buffer BRAM (80x60 pixels, 12-bit RGB444) between three requesters.
- Requester 1, display read: pixel fetch from the VGA display path, hard real-time.
- Requester 2, camera write: ov7670 capture stream, decoupled by a small write FIFO.
- Requester 3, detector read: object-detect engine, request/grant handshake.
- Sits between the capture, display and detect blocks and the BRAM; it is the only driver of the BRAM port.

Parameters:
- c_img_pxls, 4800, number of valid frame addresses (80*60).
- c_nb_img_pxls, 13, address width.
- c_nb_buf, 12, pixel word width.
- c_wfifo_depth, 4, camera write FIFO depth (power of 2).
- c_nb_wfifo, 2, log2(c_wfifo_depth).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, asynchronous, active-high.
- disp_rd  in  1  display read request, one-cycle pulse per pixel.
- disp_addr  in  c_nb_img_pxls  display read address.
- disp_data  out  c_nb_buf  display pixel, held until next display return.
- disp_valid  out  1  one-cycle pulse when disp_data updates.
- cam_we  in  1  camera write strobe.
- cam_addr  in  c_nb_img_pxls  camera write address.
- cam_data  in  c_nb_buf  camera write pixel.
- cam_full  out  1  write FIFO holds c_wfifo_depth entries.
- cam_ovf  out  1  sticky: a camera write was dropped.
- det_req  in  1  detector read request; held until granted.
- det_addr  in  c_nb_img_pxls  detector read address; stable while det_req is high.
- det_gnt  out  1  one-cycle pulse: detector request issued this cycle.
- det_data  out  c_nb_buf  detector pixel.
- det_valid  out  1  one-cycle pulse when det_data updates.
- ovf_clr  in  1  clears cam_ovf.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  c_nb_img_pxls  BRAM address.
- mem_wdata  out  c_nb_buf  BRAM write data.
- mem_rdata  in  c_nb_buf  BRAM read data, valid 1 cycle after a read is issued.

Behaviour:
- Reset (asynchronous, rst high):
  - FIFO emptied; cam_full=0, cam_ovf=0.
  - disp_data=0, det_data=0; disp_valid=0, det_valid=0, det_gnt=0.
  - Read-tag pipe cleared, so reads in flight are discarded with no valid pulse.
- Out-of-range addresses:
  - A request with addr >= c_img_pxls is never issued to the BRAM.
  - Display: disp_valid still pulses at N+2 with disp_data=0.
  - Detector: det_gnt pulses at N, det_valid at N+2 with det_data=0.
  - Camera: the write is dropped at FIFO entry; cam_ovf is not set.
- Arbitration is combinational each cycle, fixed priority:
  - 1) disp_rd.
  - 2) Camera write FIFO not empty: pop the head, write to BRAM.
  - 3) det_req.
- The winner drives mem_en/mem_we/mem_addr/mem_wdata combinationally in the same cycle N. With no winner, mem_en=0 and mem_we=0.
- Read return:
  - A 2-bit tag register (NONE/DISP/DET) records the read issued at N.
  - At N+1 mem_rdata is captured into disp_data or det_data, with the matching valid pulse.
  - Outputs are registered, so data and valid are visible at N+2.
  - Latency is fixed at 2 cycles for display reads.
- Detector handshake: det_gnt=1 in the cycle det_req wins. The requester may change det_addr or drop det_req the following cycle.
- Write FIFO:
  - Circular buffer with registered count, separate read and write pointers wrapping modulo c_wfifo_depth.
  - Push on cam_we; pop on camera grant.
  - Simultaneous push and pop: count unchanged; accepted even when full.
  - Push with count==c_wfifo_depth and no pop: data dropped, cam_ovf set (sticky).
  - Push into an empty FIFO: the entry cannot be popped before the next cycle (no bypass).
- cam_ovf:
  - Cleared by ovf_clr.
  - Set has priority over clear in the same cycle.
- Starvation: the detector may starve while the FIFO is busy or disp_rd is continuous. The display is never delayed.

Decomposition:
- Shared package fb_pkg holds:
  - c_img_pxls, c_nb_img_pxls, c_nb_buf.
  - Tag encodings TAG_NONE=0, TAG_DISP=1, TAG_DET=2.
- One sub-module: fb_wr_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count.

Test Plan:
- Reset, BRAM preloaded addr 5=12'hABC. Stimulus: disp_rd at cycle 10 with addr 5. Required: mem_en=1, mem_we=0, mem_addr=5 at cycle 10; disp_valid=1, disp_data=12'hABC at cycle 12.
- Collision: disp_rd (addr 1), FIFO holding 1 entry, and det_req (addr 2), all at cycle N. Required: display issued at N, FIFO write at N+1, det_gnt at N+2, det_valid at N+4.
- FIFO overflow: disp_rd held high 8 cycles; cam_we with addr 0..5 in cycles 0..5. Required: cam_full rises after the 4th push; pushes 5 and 6 dropped; cam_ovf=1. After disp_rd drops, BRAM addrs 0..3 written in order.
- Push with pop while full: FIFO full, cam_we in the same cycle as a camera grant. Required: count stays 4, cam_ovf stays 0, new entry written 4 grants later.
- Range check: det_req with addr 4800. Required: det_gnt pulses, mem_en stays 0, det_valid two cycles later with det_data=0. cam_we with addr 4800: no BRAM write, cam_ovf=0.
- Reset mid-read: rst asserted the cycle after a disp_rd issue. Required: no disp_valid pulse; all outputs at reset values; FIFO empty.
